// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: BIST state encoding, status LED codes and the
// SdramCtrl address split.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WR_ISSUE  = 3'd2,
    ST_WR_WAIT   = 3'd3,
    ST_RD_ISSUE  = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_DONE      = 3'd6,
    ST_TIMEOUT   = 3'd7
  } bist_state_e;

  localparam logic [7:0] LED_IDLE = 8'h00;
  localparam logic [7:0] LED_PH0  = 8'h01;
  localparam logic [7:0] LED_PH1  = 8'h02;
  localparam logic [7:0] LED_PASS = 8'h55;
  localparam logic [7:0] LED_FAIL = 8'hAA;
  localparam logic [7:0] LED_TMO  = 8'hF0;

  localparam int ROW_W = 13;
  localparam int COL_W = 9;
  localparam int BA_W  = 2;

endpackage

// File: rtl/sdram_bist.sv
// SDRAM built-in self test: writes an address-derived pattern over a window,
// reads it back, then repeats with the inverted pattern and reports status.
module sdram_bist
  import sdram_pkg::*;
#(
  parameter int              ADDR_W     = 24,
  parameter int              DATA_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = 24'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 24'h0000FF,
  parameter logic [15:0]     SEED       = 16'hF055,
  parameter int              INIT_WAIT  = 25000,
  parameter int              TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              start,
  output logic              sdram_req,
  input  logic              sdram_ack,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rh_wl,
  output logic [DATA_W-1:0] sdram_data_w,
  input  logic [DATA_W-1:0] sdram_data_r,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        led,
  output logic [2:0]        dbg_state
);

  localparam int IW_W = $clog2(INIT_WAIT);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  // Handshake: sdram_req is a one-cycle pulse in an ISSUE state; addr/rh_wl/data
  // are held from that cycle until sdram_ack, which only counts in a WAIT state.
  bist_state_e       r_state, w_state_nxt;
  logic [IW_W-1:0]   r_init_cnt;
  logic [TO_W-1:0]   r_wait_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_phase, w_phase_nxt;
  logic              r_rh_wl, w_rh_wl_nxt;
  logic [DATA_W-1:0] r_data_w;
  logic [15:0]       r_err_cnt;
  logic [ADDR_W-1:0] r_first_err;
  logic              w_upd;
  logic              w_end;
  logic              w_tmo;
  logic              w_mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic ph);
    logic [DATA_W-1:0] p;
    p = a[15:0] ^ SEED;
    return ph ? ~p : p;
  endfunction

  assign w_end      = (r_addr == END_ADDR);
  assign w_tmo      = (r_wait_cnt == TO_W'(TIMEOUT));
  assign w_mismatch = (r_state == ST_RD_WAIT) && sdram_ack &&
                      (sdram_data_r != pattern(r_addr, r_phase));

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) r_state <= ST_WAIT_INIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    w_addr_nxt  = r_addr;
    w_phase_nxt = r_phase;
    w_rh_wl_nxt = r_rh_wl;
    case (r_state)
      ST_WAIT_INIT: if (r_init_cnt == IW_W'(INIT_WAIT - 1)) w_state_nxt = ST_IDLE;
      ST_IDLE: if (start) begin
        w_state_nxt = ST_WR_ISSUE;
        w_upd       = 1'b1;
        w_addr_nxt  = START_ADDR;
        w_phase_nxt = 1'b0;
        w_rh_wl_nxt = 1'b0;
      end
      ST_WR_ISSUE: w_state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (sdram_ack) begin
          w_upd = 1'b1;
          if (w_end) begin
            w_state_nxt = ST_RD_ISSUE;
            w_addr_nxt  = START_ADDR;
            w_rh_wl_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_WR_ISSUE;
            w_addr_nxt  = r_addr + 1'b1;
          end
        end else if (w_tmo) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      ST_RD_ISSUE: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (sdram_ack) begin
          w_upd = 1'b1;
          if (w_end && !r_phase) begin
            w_state_nxt = ST_WR_ISSUE;
            w_phase_nxt = 1'b1;
            w_addr_nxt  = START_ADDR;
            w_rh_wl_nxt = 1'b0;
          end else if (w_end) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RD_ISSUE;
            w_addr_nxt  = r_addr + 1'b1;
          end
        end else if (w_tmo) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_init_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_addr      <= '0;
      r_phase     <= 1'b0;
      r_rh_wl     <= 1'b1;
      r_data_w    <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      if (r_state == ST_WAIT_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (r_state == ST_WR_WAIT || r_state == ST_RD_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                                r_wait_cnt <= '0;
      if (w_upd) begin
        r_addr   <= w_addr_nxt;
        r_phase  <= w_phase_nxt;
        r_rh_wl  <= w_rh_wl_nxt;
        r_data_w <= pattern(w_addr_nxt, w_phase_nxt);
      end
      // A zero count means this is the first miss, so capture its address.
      if (w_mismatch) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0)    r_first_err <= r_addr;
      end
    end
  end

  always_comb begin
    led = LED_IDLE;
    case (r_state)
      ST_WR_ISSUE, ST_WR_WAIT, ST_RD_ISSUE, ST_RD_WAIT: led = r_phase ? LED_PH1 : LED_PH0;
      ST_DONE:    led = (r_err_cnt == 16'd0) ? LED_PASS : LED_FAIL;
      ST_TIMEOUT: led = LED_TMO;
      default: ;
    endcase
  end

  assign sdram_req      = (r_state == ST_WR_ISSUE) || (r_state == ST_RD_ISSUE);
  assign sdram_addr     = r_addr;
  assign sdram_rh_wl    = r_rh_wl;
  assign sdram_data_w   = r_data_w;
  assign done           = (r_state == ST_DONE) || (r_state == ST_TIMEOUT);
  assign pass           = (r_state == ST_DONE) && (r_err_cnt == 16'd0);
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err;
  assign dbg_state      = r_state;

endmodule
